// File: rtl/lsu_ctrl.sv
// Load/store controller: req/ack data-memory access with lane steering and watchdog.
// Optional misaligned-access trap is compiled in with `define MISALIGN_TRAP_EN.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_st_data,
    output logic        o_ready,
    output logic        o_done,
    output logic [31:0] o_ld_data,
    output logic        o_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nx;
    logic [7:0]  wd;
    logic        is_b;
    logic        is_h;
    logic        uns;
    logic [1:0]  off;
    logic        err;
    logic        acc;
    logic        a_b;
    logic        a_h;
    logic        mis;
    logic        tmo;
    logic [3:0]  a_be;
    logic [31:0] a_wdata;
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    logic [31:0] ext;

    assign acc = i_valid & (state == IDLE);
    // 011/110/111 fall through to word along with 010
    assign a_b = (i_funct3[1:0] == 2'b00);
    assign a_h = (i_funct3[1:0] == 2'b01);
    assign tmo = (wd == TO_LAST);

`ifdef MISALIGN_TRAP_EN
    assign mis = (a_h & i_addr[0])
               | (~a_b & ~a_h & (i_addr[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        a_be    = 4'b1111;
        a_wdata = i_st_data;
        unique case (1'b1)
            a_b: begin
                a_be    = 4'b0001 << i_addr[1:0];
                a_wdata = {4{i_st_data[7:0]}};
            end
            a_h: begin
                a_be    = 4'b0011 << {i_addr[1], 1'b0};
                a_wdata = {2{i_st_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign sh_b = i_mem_rdata >> {off, 3'b000};
    assign sh_h = i_mem_rdata >> {off[1], 4'b0000};

    always_comb begin
        ext = i_mem_rdata;
        unique case (1'b1)
            is_b:    ext = {{24{~uns & sh_b[7]}}, sh_b[7:0]};
            is_h:    ext = {{16{~uns & sh_h[15]}}, sh_h[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (acc) state_nx = mis ? RESP : REQ;
            REQ:     if (i_mem_ack || tmo) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            wd          <= 8'd0;
            err         <= 1'b0;
            is_b        <= 1'b0;
            is_h        <= 1'b0;
            uns         <= 1'b0;
            off         <= 2'b00;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= 32'd0;
            o_mem_be    <= 4'd0;
            o_mem_wdata <= 32'd0;
            o_ld_data   <= 32'd0;
        end else begin
            state <= state_nx;
            wd    <= (state == REQ && !i_mem_ack) ? wd + 8'd1 : 8'd0;
            err   <= (acc & mis)
                   | ((state == REQ) & ~i_mem_ack & tmo);
            if (acc) begin
                is_b        <= a_b;
                is_h        <= a_h;
                uns         <= i_funct3[2];
                off         <= i_addr[1:0];
                o_mem_we    <= i_we;
                o_mem_addr  <= {i_addr[31:2], 2'b00};
                o_mem_be    <= a_be;
                o_mem_wdata <= a_wdata;
            end
            // stores keep the previous load result
            if (state == REQ && i_mem_ack) begin
                if (!o_mem_we) o_ld_data <= ext;
            end else if (state == REQ && tmo) begin
                o_ld_data <= 32'd0;
            end else if (acc && mis) begin
                o_ld_data <= 32'd0;
            end
        end
    end

    assign o_ready   = (state == IDLE);
    assign o_mem_req = (state == REQ);
    assign o_done    = (state == RESP);
    assign o_err     = err;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed loads/stores, timeout, reset abort.
// Misaligned-access vectors follow MISALIGN_TRAP_EN.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic        ready;
    logic        done;
    logic [31:0] ld_data;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] ld;
        logic        err;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    lsu_ctrl #(.TIMEOUT(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (valid),
        .i_we        (we),
        .i_funct3    (funct3),
        .i_addr      (addr),
        .i_st_data   (st_data),
        .o_ready     (ready),
        .o_done      (done),
        .o_ld_data   (ld_data),
        .o_err       (err),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_be    (mem_be),
        .o_mem_wdata (mem_wdata),
        .i_mem_ack   (mem_ack),
        .i_mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1 expected none");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.nm, " ld_data"}, ld_data, e.ld);
                chk({e.nm, " err"}, {31'd0, err}, {31'd0, e.err});
            end
        end
        if (rst_n && err && !done) begin
            checks++;
            errors++;
            $display("FAIL err_without_done: got err=1 expected 0");
        end
    end

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk({nm, " ready_wait"}, 32'd0, 32'd1);
    endtask

    // dly < 0 means never ack (watchdog path)
    task automatic run(
        input string       nm,
        input logic        w,
        input logic [2:0]  f3,
        input logic [31:0] a,
        input logic [31:0] sd,
        input int          dly,
        input logic [31:0] rd,
        input logic        e_req,
        input logic [31:0] e_addr,
        input logic [3:0]  e_be,
        input logic [31:0] e_wd,
        input logic [31:0] e_ld,
        input logic        e_err
    );
        exp_t e;
        int   n;
        wait_ready(nm);
        valid   = 1'b1;
        we      = w;
        funct3  = f3;
        addr    = a;
        st_data = sd;
        e.ld  = e_ld;
        e.err = e_err;
        e.nm  = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        valid   = 1'b0;
        addr    = 32'hFFFF_FFFF;
        st_data = 32'h0BAD_0BAD;
        @(negedge clk);
        if (e_req) begin
            chk({nm, " req"}, {31'd0, mem_req}, 32'd1);
            chk({nm, " addr"}, mem_addr, e_addr);
            chk({nm, " be"}, {28'd0, mem_be}, {28'd0, e_be});
            chk({nm, " wdata"}, mem_wdata, e_wd);
            chk({nm, " we"}, {31'd0, mem_we}, {31'd0, w});
            if (dly < 0) begin
                n = 0;
                while (mem_req && n < 50) begin
                    n++;
                    @(negedge clk);
                end
                chk({nm, " req_cycles"}, n, 4);
            end else begin
                repeat (dly) @(negedge clk);
                mem_ack   = 1'b1;
                mem_rdata = rd;
                @(posedge clk);
                #1;
                mem_ack   = 1'b0;
                mem_rdata = 32'h0;
                @(negedge clk);
            end
        end else begin
            chk({nm, " no_req"}, {31'd0, mem_req}, 32'd0);
        end
        chk({nm, " done"}, {31'd0, done}, 32'd1);
        mem_ack = (dly < 0);
        @(negedge clk);
        chk({nm, " done_once"}, {31'd0, done}, 32'd0);
        mem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        valid     = 1'b0;
        we        = 1'b0;
        funct3    = 3'b000;
        addr      = 32'h0;
        st_data   = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        #12;
        chk("rst ready", {31'd0, ready}, 32'd1);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst err", {31'd0, err}, 32'd0);
        chk("rst req", {31'd0, mem_req}, 32'd0);
        chk("rst we", {31'd0, mem_we}, 32'd0);
        chk("rst addr", mem_addr, 32'd0);
        chk("rst be", {28'd0, mem_be}, 32'd0);
        chk("rst wdata", mem_wdata, 32'd0);
        chk("rst ld", ld_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run("sw", 1, 3'b010, 32'h1008, 32'hDEADBEEF, 2, 32'h0,
            1, 32'h1008, 4'b1111, 32'hDEADBEEF, 32'h0, 0);
        run("sb", 1, 3'b000, 32'h0103, 32'h000000A5, 0, 32'h0,
            1, 32'h0100, 4'b1000, 32'hA5A5A5A5, 32'h0, 0);
        run("lb", 0, 3'b000, 32'h2001, 32'h0, 1, 32'h123480FF,
            1, 32'h2000, 4'b0010, 32'h0, 32'hFFFFFF80, 0);
        run("lbu", 0, 3'b100, 32'h2001, 32'h0, 0, 32'h123480FF,
            1, 32'h2000, 4'b0010, 32'h0, 32'h00000080, 0);
        run("lhu", 0, 3'b101, 32'h2002, 32'h0, 3, 32'h123480FF,
            1, 32'h2000, 4'b1100, 32'h0, 32'h00001234, 0);
        run("lh", 0, 3'b001, 32'h2000, 32'h0, 0, 32'h00008001,
            1, 32'h2000, 4'b0011, 32'h0, 32'hFFFF8001, 0);
        run("sh", 1, 3'b001, 32'h2006, 32'h1234BEEF, 1, 32'h0,
            1, 32'h2004, 4'b1100, 32'hBEEFBEEF, 32'hFFFF8001, 0);
        run("lw", 0, 3'b010, 32'h2004, 32'h0, 0, 32'hCAFEF00D,
            1, 32'h2004, 4'b1111, 32'h0, 32'hCAFEF00D, 0);
        run("timeout", 0, 3'b010, 32'h0040, 32'h0, -1, 32'h0,
            1, 32'h0040, 4'b1111, 32'h0, 32'h0, 1);
`ifdef MISALIGN_TRAP_EN
        run("lw_mis", 0, 3'b010, 32'h3002, 32'h0, 0, 32'h11223344,
            0, 32'h0, 4'b0000, 32'h0, 32'h0, 1);
        run("lh_mis", 0, 3'b001, 32'h2003, 32'h0, 0, 32'hBEEF0000,
            0, 32'h0, 4'b0000, 32'h0, 32'h0, 1);
`else
        run("lw_mis", 0, 3'b010, 32'h3002, 32'h0, 0, 32'h11223344,
            1, 32'h3000, 4'b1111, 32'h0, 32'h11223344, 0);
        run("lh_mis", 0, 3'b001, 32'h2003, 32'h0, 0, 32'hBEEF0000,
            1, 32'h2000, 4'b1100, 32'h0, 32'hFFFFBEEF, 0);
`endif
        run("f3_111", 0, 3'b111, 32'h3004, 32'h0, 0, 32'h55AA55AA,
            1, 32'h3004, 4'b1111, 32'h0, 32'h55AA55AA, 0);

        wait_ready("rst_mid");
        valid  = 1'b1;
        we     = 1'b0;
        funct3 = 3'b010;
        addr   = 32'h0500;
        @(posedge clk);
        #1;
        valid = 1'b0;
        @(negedge clk);
        chk("rst_mid req_before", {31'd0, mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid req_async", {31'd0, mem_req}, 32'd0);
        chk("rst_mid done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid ready", {31'd0, ready}, 32'd1);
        chk("rst_mid ld", ld_data, 32'd0);

        run("sw_post", 1, 3'b010, 32'h0008, 32'h00000001, 0, 32'h0,
            1, 32'h0008, 4'b1111, 32'h00000001, 32'h0, 0);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
